// File: rtl/delay_cfg_loader.sv
// Parses 8-byte UART command frames and commits 24-bit delay words to the
// per-channel delay RAM write ports. Everything runs in the UART clock domain.
module delay_cfg_loader #(
    parameter logic [7:0] HEADER_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        I_UART_CLK,
    input  logic        I_RST,
    input  logic [7:0]  I_RX_DATA,
    input  logic        I_RX_VALID,
    output logic        O_WEA_RAM1,
    output logic        O_WEA_RAM2,
    output logic        O_WEA_RAM3,
    output logic        O_WEA_RAM4,
    output logic [10:0] O_WRITE_ADDR_RAM1,
    output logic [10:0] O_WRITE_ADDR_RAM2,
    output logic [10:0] O_WRITE_ADDR_RAM3,
    output logic [10:0] O_WRITE_ADDR_RAM4,
    output logic [23:0] O_WRITE_DELAY_RAM1,
    output logic [23:0] O_WRITE_DELAY_RAM2,
    output logic [23:0] O_WRITE_DELAY_RAM3,
    output logic [23:0] O_WRITE_DELAY_RAM4,
    output logic        O_FRAME_OK,
    output logic        O_FRAME_ERR,
    output logic [1:0]  O_ERR_CODE,
    output logic        O_BUSY
);

    typedef enum logic [2:0] {
        IDLE, MASK, ADDR_H, ADDR_L, DLY_H, DLY_M, DLY_L, CSUM
    } state_t;

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [23:0]       idle_cnt;
    logic [7:0]        mask_b, addr_h_b, addr_l_b, dly_h_b, dly_m_b, dly_l_b;
    logic [3:0]        wea_q;
    logic [3:0][10:0]  addr_q;
    logic [3:0][23:0]  dly_q;
    logic              ok_q, err_q;
    logic [1:0]        code_q;
    logic [2:0]        verdict;

    // Returns {reject, code}; checks are ordered so the first failure wins.
    function automatic logic [2:0] frame_check(input logic [7:0] csum_rx,
                                               input logic [7:0] csum_calc,
                                               input logic [7:0] mask,
                                               input logic [7:0] addr_h);
        if (csum_rx != csum_calc)
            return {1'b1, 2'd1};
        else if (mask == 8'd0 || mask[7:4] != 4'd0)
            return {1'b1, 2'd2};
        else if (addr_h[7:3] != 5'd0)
            return {1'b1, 2'd3};
        else
            return 3'b000;
    endfunction

    assign verdict = frame_check(I_RX_DATA,
                                 mask_b ^ addr_h_b ^ addr_l_b ^ dly_h_b ^ dly_m_b ^ dly_l_b,
                                 mask_b, addr_h_b);

    // Frame byte capture; these are only consumed once a full frame is in.
    always_ff @(posedge I_UART_CLK) begin
        if (I_RX_VALID) begin
            case (state)
                MASK:    mask_b   <= I_RX_DATA;
                ADDR_H:  addr_h_b <= I_RX_DATA;
                ADDR_L:  addr_l_b <= I_RX_DATA;
                DLY_H:   dly_h_b  <= I_RX_DATA;
                DLY_M:   dly_m_b  <= I_RX_DATA;
                DLY_L:   dly_l_b  <= I_RX_DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_UART_CLK) begin
        if (I_RST) begin
            state    <= IDLE;
            idle_cnt <= 24'd0;
            wea_q    <= 4'd0;
            addr_q   <= '0;
            dly_q    <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            wea_q <= 4'd0;
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            if (state == IDLE) begin
                idle_cnt <= 24'd0;
                if (I_RX_VALID && I_RX_DATA == HEADER_BYTE)
                    state <= MASK;
            end else if (I_RX_VALID) begin
                // A byte always wins over an expiring timeout.
                idle_cnt <= 24'd0;
                case (state)
                    MASK:    state <= ADDR_H;
                    ADDR_H:  state <= ADDR_L;
                    ADDR_L:  state <= DLY_H;
                    DLY_H:   state <= DLY_M;
                    DLY_M:   state <= DLY_L;
                    DLY_L:   state <= CSUM;
                    default: begin
                        state <= IDLE;
                        if (verdict[2]) begin
                            err_q  <= 1'b1;
                            code_q <= verdict[1:0];
                        end else begin
                            ok_q <= 1'b1;
                            for (int n = 0; n < 4; n++) begin
                                if (mask_b[n]) begin
                                    wea_q[n]  <= 1'b1;
                                    addr_q[n] <= {addr_h_b[2:0], addr_l_b};
                                    dly_q[n]  <= {dly_h_b, dly_m_b, dly_l_b};
                                end
                            end
                        end
                    end
                endcase
            end else if (idle_cnt == TO_LAST) begin
                state    <= IDLE;
                idle_cnt <= 24'd0;
                err_q    <= 1'b1;
                code_q   <= 2'd0;
            end else begin
                idle_cnt <= idle_cnt + 24'd1;
            end
        end
    end

    assign O_WEA_RAM1         = wea_q[0];
    assign O_WEA_RAM2         = wea_q[1];
    assign O_WEA_RAM3         = wea_q[2];
    assign O_WEA_RAM4         = wea_q[3];
    assign O_WRITE_ADDR_RAM1  = addr_q[0];
    assign O_WRITE_ADDR_RAM2  = addr_q[1];
    assign O_WRITE_ADDR_RAM3  = addr_q[2];
    assign O_WRITE_ADDR_RAM4  = addr_q[3];
    assign O_WRITE_DELAY_RAM1 = dly_q[0];
    assign O_WRITE_DELAY_RAM2 = dly_q[1];
    assign O_WRITE_DELAY_RAM3 = dly_q[2];
    assign O_WRITE_DELAY_RAM4 = dly_q[3];
    assign O_FRAME_OK         = ok_q;
    assign O_FRAME_ERR        = err_q;
    assign O_ERR_CODE         = code_q;
    assign O_BUSY             = (state != IDLE);

endmodule

// File: tb/tb_delay_cfg_loader.sv
// Scoreboard bench for delay_cfg_loader: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever a write or frame pulse appears.
module tb_delay_cfg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        wea1, wea2, wea3, wea4;
    logic [10:0] addr1, addr2, addr3, addr4;
    logic [23:0] dly1, dly2, dly3, dly4;
    logic        frame_ok, frame_err, busy;
    logic [1:0]  err_code;

    typedef struct packed {
        logic [3:0]       wea;
        logic             ok;
        logic             err;
        logic [1:0]       code;
        logic [3:0][10:0] addr;
        logic [3:0][23:0] dly;
    } ev_t;

    ev_t              exp_q[$];
    logic [3:0][10:0] m_addr = '0;
    logic [3:0][23:0] m_dly  = '0;
    logic [1:0]       m_code = 2'd0;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    delay_cfg_loader #(.HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .I_UART_CLK(clk), .I_RST(rst), .I_RX_DATA(rx_data), .I_RX_VALID(rx_valid),
        .O_WEA_RAM1(wea1), .O_WEA_RAM2(wea2), .O_WEA_RAM3(wea3), .O_WEA_RAM4(wea4),
        .O_WRITE_ADDR_RAM1(addr1), .O_WRITE_ADDR_RAM2(addr2),
        .O_WRITE_ADDR_RAM3(addr3), .O_WRITE_ADDR_RAM4(addr4),
        .O_WRITE_DELAY_RAM1(dly1), .O_WRITE_DELAY_RAM2(dly2),
        .O_WRITE_DELAY_RAM3(dly3), .O_WRITE_DELAY_RAM4(dly4),
        .O_FRAME_OK(frame_ok), .O_FRAME_ERR(frame_err), .O_ERR_CODE(err_code),
        .O_BUSY(busy)
    );

    function automatic ev_t snapshot();
        ev_t a;
        a.wea  = {wea4, wea3, wea2, wea1};
        a.ok   = frame_ok;
        a.err  = frame_err;
        a.code = err_code;
        a.addr = {addr4, addr3, addr2, addr1};
        a.dly  = {dly4, dly3, dly2, dly1};
        return a;
    endfunction

    task automatic expect_ok(input logic [3:0] mask, input logic [10:0] addr,
                             input logic [23:0] dly);
        ev_t e;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) begin
                m_addr[n] = addr;
                m_dly[n]  = dly;
            end
        end
        e.wea = mask; e.ok = 1'b1; e.err = 1'b0; e.code = m_code;
        e.addr = m_addr; e.dly = m_dly;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] code);
        ev_t e;
        m_code = code;
        e.wea = 4'd0; e.ok = 1'b0; e.err = 1'b1; e.code = code;
        e.addr = m_addr; e.dly = m_dly;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] mask, input logic [7:0] ah,
                              input logic [7:0] al, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0,
                              input logic [7:0] csum_flip);
        send_byte(8'hA5);
        send_byte(mask);
        send_byte(ah);
        send_byte(al);
        send_byte(d2);
        send_byte(d1);
        send_byte(d0);
        send_byte(mask ^ ah ^ al ^ d2 ^ d1 ^ d0 ^ csum_flip);
    endtask

    task automatic check_busy(input string name, input logic want);
        checks++;
        if (busy !== want) begin
            errors++;
            $display("FAIL %s: busy=%0b expected=%0b", name, busy, want);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        ev_t a;
        a = snapshot();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h expected all zero", name, a);
        end
    endtask

    // Monitor: every write/ok/err pulse must match the next queued event.
    initial begin
        ev_t a, e;
        forever begin
            @(negedge clk);
            if (!rst && (wea1 || wea2 || wea3 || wea4 || frame_ok || frame_err)) begin
                a = snapshot();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got=%h expected none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL event: wea=%b ok=%b err=%b code=%0d addr=%h dly=%h | expected wea=%b ok=%b err=%b code=%0d addr=%h dly=%h",
                                 a.wea, a.ok, a.err, a.code, a.addr, a.dly,
                                 e.wea, e.ok, e.err, e.code, e.addr, e.dly);
                    end
                end
            end
        end
    end

    initial begin
        stall(3);
        check_zero_outputs("reset_outputs");
        check_busy("reset_busy", 1'b0);
        rst = 1'b0;
        stall(2);

        // Single-channel commit, checksum 8D.
        expect_ok(4'b0001, 11'h3FF, 24'h123456);
        send_frame(8'h01, 8'h03, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h00);

        // Broadcast followed back-to-back by a channel-2-only frame.
        expect_ok(4'b1111, 11'd5, 24'd10);
        expect_ok(4'b0010, 11'd5, 24'd7);
        send_frame(8'h0F, 8'h00, 8'h05, 8'h00, 8'h00, 8'h0A, 8'h00);
        send_frame(8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h07, 8'h00);

        // Rejections: bad checksum, bad mask, bad address high byte.
        expect_err(2'd1);
        send_frame(8'h01, 8'h03, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h01);
        expect_err(2'd2);
        send_frame(8'h10, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'h00);
        expect_err(2'd3);
        send_frame(8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
        stall(2);

        // Timeout after 16 silent cycles.
        expect_err(2'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        stall(16);
        check_busy("timeout_busy", 1'b0);
        stall(2);

        // Byte on the expiry cycle keeps the frame alive.
        send_byte(8'hA5);
        send_byte(8'h01);
        stall(15);
        check_busy("pre_expiry_busy", 1'b1);
        expect_ok(4'b0001, 11'd7, 24'd9);
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h09);
        send_byte(8'h0F);
        stall(2);

        // Garbage before a header is ignored.
        send_byte(8'h00);
        send_byte(8'h33);
        expect_ok(4'b0100, 11'h2AB, 24'h00BEEF);
        send_frame(8'h04, 8'h02, 8'hAB, 8'h00, 8'hBE, 8'hEF, 8'h00);
        stall(2);

        // Reset mid-frame discards it silently and clears every output.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_addr = '0;
        m_dly  = '0;
        m_code = 2'd0;
        check_busy("reset_midframe_busy", 1'b0);
        check_zero_outputs("reset_midframe_outputs");
        expect_ok(4'b1000, 11'h7FF, 24'hAABBCC);
        send_frame(8'h08, 8'h07, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'h00);
        stall(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: outstanding=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
